tone_period_meter: RTL and testbench
====================================

Name: tone_period_meter

Overview:
- Receive-side counterpart of the square-wave tone generator: measures the period of an incoming tone square wave in clk cycles.
- Reports the period as a divider-compatible value, so a generator driven with div = N measures back as N.
- Used for loopback self-test of the music player and for pitch capture from an external tone source.
- Sits between an input pin and the note-lookup/control logic.

Parameters:
- CNT_W, 32, width of the period counter and of the period output.
- AVG_LOG2, 0, number of periods averaged per report, as log2 (0 means every period is reported, 2 means 4 periods are averaged).
- MAX_PERIOD, 32'd50_000_000, timeout in clk cycles without a rising edge before the input is declared silent.
- GLITCH_CYC, 4, minimum stable cycles before an input level is accepted (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- tone_in  in  1  asynchronous square-wave input
- period  out  CNT_W  last measured (averaged) period in clk cycles
- period_valid  out  1  one-cycle pulse when period updates
- no_signal  out  1  high while the input is silent or not yet locked

Behaviour:
- Reset (rst==0 sampled on posedge clk):
  - period=0, period_valid=0, no_signal=1.
  - Synchroniser, counter and accumulator all cleared.
  - State = IDLE.
  - Reset mid-measurement discards the partial period and accumulator.
- Input path:
  - Two-flop synchroniser, then a delay flop.
  - rise = s2 & ~s3.
  - Rise is detected 3 clk edges after tone_in goes high.
- States:
  - IDLE: waiting for the first rise. On rise: cnt<=1, go to ARMED. No output.
  - ARMED, no rise: cnt increments, saturating at MAX_PERIOD.
  - ARMED, rise: sample=cnt; cnt<=1; acc<=acc+sample; num<=num+1.
  - ARMED, report: when num reaches 2^AVG_LOG2-1 at a rise, on the same clock:
    - period <= (acc+sample)>>AVG_LOG2 (truncating);
    - period_valid<=1;
    - no_signal<=0;
    - acc, num cleared.
  - ARMED, timeout: cnt==MAX_PERIOD with no rise. Then no_signal<=1, period<=0, acc/num/cnt cleared, go to IDLE. Timeout has priority over a rise in the same cycle.
- Measured value:
  - Count of clk cycles between consecutive detected rises.
  - A steady input with rises every N cycles yields period=N.
  - The minimum measurable period is 2.
- Widths:
  - acc is CNT_W+AVG_LOG2 bits, so no overflow.
  - cnt never exceeds MAX_PERIOD.
- Timing:
  - period_valid is high for exactly one cycle per report and is never asserted in IDLE.
  - The first report needs 2^AVG_LOG2+1 rises after IDLE.

Optional Feature:
- Macro: TONE_DEGLITCH_EN.
- Defined:
  - The level after the synchroniser passes a stability filter.
  - The filtered level changes only after the raw synchronised level differs from it for GLITCH_CYC consecutive cycles.
  - Pulses shorter than GLITCH_CYC are ignored.
  - Adds GLITCH_CYC cycles of latency but does not change the measured period.
- Undefined:
  - No filter; the synchronised level drives edge detection directly.

Decomposition:
- Package music_pkg:
  - CNT_W default.
  - Note divider constants (e.g. DIV_C4, DIV_A4) shared with the tone generator.
  - State enum: IDLE, ARMED.
- Sub-module tone_edge_sync:
  - Synchroniser, optional deglitch filter and rise detect.
  - Output: rise.
- The top level holds the counter, accumulator, timeout and FSM.

Test Plan:
- Reset with no edges, AVG_LOG2=0: expect no_signal=1, period=0 and no valid pulse. Then drive a generator-style wave with div=1000 for 5 periods: expect 4 period_valid pulses, each with period=1000, and no_signal=0 after the first.
- AVG_LOG2=2, alternating periods of 1000 and 1002 cycles: expect one valid pulse every 4 periods with period=1001.
- MAX_PERIOD=5000, lock at period 1000, then hold tone_in low: expect no_signal=1 and period=0 exactly 5000 cycles after the last rise. On resuming, the first valid pulse comes on the second rise.
- Assert rst for 1 cycle mid-period while locked at 2000: expect outputs at reset values. The next report needs two new rises and reads 2000.
- Period=2 (tone_in toggling every cycle) with AVG_LOG2=0: expect period=2 on every rise.
- With TONE_DEGLITCH_EN and GLITCH_CYC=4, inject 2-cycle high glitches into a period-1000 wave: period stays 1000 with no extra valid pulses. Without the macro, the glitches produce short periods.

Source files
------------

// File: rtl/music_pkg.sv
// Shared music-player constants: counter width, tone dividers and meter state.
// Divider values assume a 50 MHz clk (generator div = clk cycles per period).
package music_pkg;

  localparam int CNT_W_DEF = 32;

  localparam int unsigned DIV_C4 = 191_113;
  localparam int unsigned DIV_A4 = 113_636;

  typedef enum logic {IDLE, ARMED} meter_state_t;

endpackage

// File: rtl/tone_edge_sync.sv
// Synchronises tone_in and flags its rising edges for one cycle.
// With TONE_DEGLITCH_EN defined, a GLITCH_CYC stability filter precedes edge detection.
module tone_edge_sync #(
  parameter int GLITCH_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic rise
);

  logic s1, s2, s3, lvl;

  if (GLITCH_CYC < 1) begin : g_bad_glitch
    $error("GLITCH_CYC must be at least 1");
  end

`ifdef TONE_DEGLITCH_EN
  localparam int GW = $clog2(GLITCH_CYC + 1);
  logic [GW-1:0] run;

  // lvl follows s2 only after GLITCH_CYC consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      run <= '0;
      lvl <= 1'b0;
    end else if (s2 != lvl) begin
      if (run == GW'(GLITCH_CYC - 1)) begin
        lvl <= s2;
        run <= '0;
      end else begin
        run <= run + 1'b1;
      end
    end else begin
      run <= '0;
    end
  end
`else
  assign lvl = s2;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tone_in;
      s2 <= s1;
      s3 <= lvl;
    end
  end

  assign rise = lvl & ~s3;

endmodule

// File: rtl/tone_period_meter.sv
// Measures the tone_in period in clk cycles, optionally averaged over 2^AVG_LOG2 periods.
// Optional input deglitching is enabled with the TONE_DEGLITCH_EN macro.
module tone_period_meter
  import music_pkg::*;
#(
  parameter int          CNT_W      = CNT_W_DEF,
  parameter int          AVG_LOG2   = 0,
  parameter int unsigned MAX_PERIOD = 32'd50_000_000,
  parameter int          GLITCH_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             no_signal
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int NUM_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [NUM_W-1:0] NUM_LAST = NUM_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PERIOD);

  meter_state_t     state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, period_nx;
  logic [ACC_W-1:0] acc, acc_nx, sum;
  logic [NUM_W-1:0] num, num_nx;
  logic             valid_nx, nosig_nx, rise;

  tone_edge_sync #(.GLITCH_CYC(GLITCH_CYC)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .tone_in (tone_in),
    .rise    (rise)
  );

  // accumulator including the period that just closed
  assign sum = acc + ACC_W'(cnt);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    acc_nx    = acc;
    num_nx    = num;
    period_nx = period;
    valid_nx  = 1'b0;
    nosig_nx  = no_signal;
    case (state)
      IDLE: begin
        if (rise) begin
          cnt_nx   = CNT_W'(1);
          state_nx = ARMED;
        end
      end
      ARMED: begin
        if (cnt == MAX_CNT) begin
          // silent input wins over a coincident rise
          state_nx  = IDLE;
          cnt_nx    = '0;
          acc_nx    = '0;
          num_nx    = '0;
          period_nx = '0;
          nosig_nx  = 1'b1;
        end else if (rise) begin
          cnt_nx = CNT_W'(1);
          if (num == NUM_LAST) begin
            period_nx = CNT_W'(sum >> AVG_LOG2);
            valid_nx  = 1'b1;
            nosig_nx  = 1'b0;
            acc_nx    = '0;
            num_nx    = '0;
          end else begin
            acc_nx = sum;
            num_nx = num + 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      num          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      no_signal    <= 1'b1;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      acc          <= acc_nx;
      num          <= num_nx;
      period       <= period_nx;
      period_valid <= valid_nx;
      no_signal    <= nosig_nx;
    end
  end

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter: one unaveraged and one 4-period-averaged
// instance share clk, rst and tone_in; TONE_DEGLITCH_EN selects glitch expectations.
module tb_tone_period_meter;

  localparam int MAXP = 5000;
`ifdef TONE_DEGLITCH_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tone = 1'b0;
  logic [31:0] period0, period2;
  logic        valid0, valid2, nosig0, nosig2;

  int errors = 0;
  int checks = 0;
  int q0[$];
  int q2[$];

  always #5 clk = ~clk;

  tone_period_meter #(.CNT_W(32), .AVG_LOG2(0), .MAX_PERIOD(MAXP), .GLITCH_CYC(4)) dut0 (
    .clk(clk), .rst(rst), .tone_in(tone),
    .period(period0), .period_valid(valid0), .no_signal(nosig0)
  );

  tone_period_meter #(.CNT_W(32), .AVG_LOG2(2), .MAX_PERIOD(MAXP), .GLITCH_CYC(4)) dut2 (
    .clk(clk), .rst(rst), .tone_in(tone),
    .period(period2), .period_valid(valid2), .no_signal(nosig2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance n cycles, logging every report at the falling edge
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      if (valid0) q0.push_back(int'(period0));
      if (valid2) q2.push_back(int'(period2));
    end
  endtask

  task automatic wave(input int per, input int n);
    for (int p = 0; p < n; p++) begin
      tone = 1'b1;
      cyc(per / 2);
      tone = 1'b0;
      cyc(per - per / 2);
    end
  endtask

  task automatic clrq();
    q0.delete();
    q2.delete();
  endtask

  initial begin
    // reset values and quiet idle
    cyc(3);
    chk("rst_period", period0, 0);
    chk("rst_nosig", nosig0, 1);
    chk("rst_valid", valid0, 0);
    rst = 1'b1;
    cyc(20);
    chk("idle_reports", q0.size(), 0);
    chk("idle_nosig", nosig0, 1);
    chk("idle_period", period0, 0);

    // div=1000, five periods
    clrq();
    wave(1000, 5);
    chk("d1000_count", q0.size(), 4);
    for (int i = 0; i < 4; i++) chk("d1000_val", q0[i], 1000);
    chk("d1000_nosig", nosig0, 0);
    chk("avg_first_count", q2.size(), 1);
    chk("avg_first_val", q2[0], 1000);

    // alternating 1000/1002, averaged over 4
    clrq();
    for (int i = 0; i < 4; i++) begin
      wave(1002, 1);
      wave(1000, 1);
    end
    chk("avg_count", q2.size(), 2);
    chk("avg_val0", q2[0], 1001);
    chk("avg_val1", q2[1], 1001);
    chk("alt_count", q0.size(), 8);
    chk("alt_val1", q0[1], 1002);

    // timeout exactly MAXP cycles after the last rise
    wave(1000, 2);
    tone = 1'b1;
    for (int i = 1; i <= LAT + MAXP; i++) begin
      cyc();
      if (i == 500) tone = 1'b0;
      if (i == LAT + MAXP - 1) chk("timeout_early", nosig0, 0);
    end
    chk("timeout_nosig", nosig0, 1);
    chk("timeout_period", period0, 0);
    chk("timeout_nosig_avg", nosig2, 1);
    clrq();
    wave(1000, 2);
    chk("resume_count", q0.size(), 1);
    chk("resume_val", q0[0], 1000);
    chk("resume_avg_count", q2.size(), 0);

    // reset mid-period while locked at 2000
    wave(2000, 2);
    chk("lock2000", period0, 2000);
    tone = 1'b1;
    cyc(1000);
    tone = 1'b0;
    cyc(500);
    rst = 1'b0;
    cyc();
    chk("midrst_period", period0, 0);
    chk("midrst_nosig", nosig0, 1);
    chk("midrst_valid", valid0, 0);
    chk("midrst_nosig_avg", nosig2, 1);
    rst = 1'b1;
    clrq();
    cyc(499);
    wave(2000, 2);
    chk("post_rst_count", q0.size(), 1);
    chk("post_rst_val", q0[0], 2000);

`ifndef TONE_DEGLITCH_EN
    // minimum period: toggle every cycle
    clrq();
    for (int i = 0; i < 20; i++) begin
      tone = 1'b1;
      cyc();
      tone = 1'b0;
      cyc();
    end
    cyc(10);
    chk("p2_count", q0.size(), 20);
    chk("p2_first", q0[0], 2000);
    for (int i = 1; i < 20; i++) chk("p2_val", q0[i], 2);
`endif

    // 2-cycle high glitches 700 cycles into each period-1000 wave
    wave(1000, 2);
    clrq();
    for (int p = 0; p < 4; p++) begin
      tone = 1'b1;
      cyc(500);
      tone = 1'b0;
      cyc(200);
      tone = 1'b1;
      cyc(2);
      tone = 1'b0;
      cyc(298);
    end
    tone = 1'b1;
    cyc(10);
    tone = 1'b0;
    cyc(10);
`ifdef TONE_DEGLITCH_EN
    chk("glitch_count", q0.size(), 5);
    for (int i = 0; i < 5; i++) chk("glitch_val", q0[i], 1000);
`else
    chk("glitch_count", q0.size(), 9);
    chk("glitch_first", q0[0], 1000);
    for (int i = 1; i < 9; i++) chk("glitch_val", q0[i], (i % 2 == 1) ? 700 : 300);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
